// File: rtl/gpio_db_pkg.sv
// Shared definitions for the debounced Avalon-MM GPIO block:
// register word addresses, bus width and debounce counter sizing.
package gpio_db_pkg;

  localparam int REG_W = 32;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd6;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd7;

  // Counter must hold values up to DB_CYCLES.
  function automatic int cnt_width(input int db);
    return $clog2(db + 1);
  endfunction

endpackage

// File: rtl/gpio_db_chan.sv
// One input channel: synchroniser, polarity inversion, debounce.
// Ports: Clk, Reset, pin (raw), stable (debounced), upd (stable flips next edge).
module gpio_db_chan
  import gpio_db_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 500000,
  parameter logic INV         = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pin,
  output logic stable,
  output logic upd
);

  localparam int CW = cnt_width(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   stable_q;
  logic                   s;
  logic                   last;

  assign s      = sync[SYNC_STAGES-1] ^ INV;
  assign last   = (cnt == CW'(DB_CYCLES - 1));
  assign upd    = (s != stable_q) && last;
  assign stable = stable_q;

  // Sync flops reset to the idle pin level so the
  // inverted value starts at 0 and no edge appears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync     <= {SYNC_STAGES{INV}};
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      if (s == stable_q) begin
        cnt <= '0;
      end else if (last) begin
        stable_q <= s;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/avalon_gpio_db.sv
// Avalon-MM GPIO: debounced inputs, edge capture with IRQ, set/clear outputs.
// Ports: Clk, Reset, avs_* slave bus, irq, pin_in (raw), pin_out.
module avalon_gpio_db
  import gpio_db_pkg::*;
#(
  parameter int              N_IN        = 10,
  parameter int              N_OUT       = 8,
  parameter int              DB_CYCLES   = 500000,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_IN-1:0] INV_MASK    = 10'b11_0000_0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             avs_chipselect,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [N_IN-1:0]  pin_in,
  output logic [N_OUT-1:0] pin_out
);

  logic [N_IN-1:0]  stable;
  logic [N_IN-1:0]  upd;
  logic [N_IN-1:0]  ev;
  logic [N_IN-1:0]  w1c;
  logic [N_IN-1:0]  irq_mask;
  logic [N_IN-1:0]  edge_cap;
  logic [N_IN-1:0]  rise_en;
  logic [N_IN-1:0]  fall_en;
  logic [N_OUT-1:0] data_out;
  logic [N_IN-1:0]  wd_in;
  logic [N_OUT-1:0] wd_out;
  logic [REG_W-1:0] rdata;
  logic             wr;
  logic             rd;
  logic             unused_wd;

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    gpio_db_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .INV        (INV_MASK[i])
    ) u_chan (
      .Clk   (Clk),
      .Reset (Reset),
      .pin   (pin_in[i]),
      .stable(stable[i]),
      .upd   (upd[i])
    );
  end

  assign wr     = avs_chipselect && avs_write;
  assign rd     = avs_chipselect && avs_read;
  assign wd_in  = avs_writedata[N_IN-1:0];
  assign wd_out = avs_writedata[N_OUT-1:0];
  assign unused_wd = ^avs_writedata;

  // upd with stable=0 means a 0->1 transition lands this edge.
  assign ev = (upd & ~stable & rise_en)
            | (upd &  stable & fall_en);

  assign w1c = (wr && avs_address == ADDR_EDGE_CAP) ? wd_in : '0;

  assign pin_out = data_out;

  always_comb begin
    rdata = '0;
    case (avs_address)
      ADDR_DATA_IN:  rdata = REG_W'(stable);
      ADDR_DATA_OUT: rdata = REG_W'(data_out);
      ADDR_IRQ_MASK: rdata = REG_W'(irq_mask);
      ADDR_EDGE_CAP: rdata = REG_W'(edge_cap);
      ADDR_RISE_EN:  rdata = REG_W'(rise_en);
      ADDR_FALL_EN:  rdata = REG_W'(fall_en);
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_out     <= '0;
      irq_mask     <= '0;
      edge_cap     <= '0;
      rise_en      <= '1;
      fall_en      <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (rd) avs_readdata <= rdata;
      irq      <= |(edge_cap & irq_mask);
      // New events override a same-cycle clear.
      edge_cap <= (edge_cap & ~w1c) | ev;
      if (wr) begin
        case (avs_address)
          ADDR_DATA_OUT: data_out <= wd_out;
          ADDR_IRQ_MASK: irq_mask <= wd_in;
          ADDR_RISE_EN:  rise_en  <= wd_in;
          ADDR_FALL_EN:  fall_en  <= wd_in;
          ADDR_OUT_SET:  data_out <= data_out | wd_out;
          ADDR_OUT_CLR:  data_out <= data_out & ~wd_out;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avalon_gpio_db.sv
// Scoreboard bench for avalon_gpio_db with DB_CYCLES=4, SYNC_STAGES=2.
// Stimulus pushes expectations; a posedge monitor pops and compares.
module tb_avalon_gpio_db;

  localparam int SRC_RD   = 0;
  localparam int SRC_IRQ  = 1;
  localparam int SRC_POUT = 2;
  localparam int SRC_RDQ  = 3;

  typedef struct {
    int          src;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        avs_chipselect;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [9:0]  pin_in;
  logic [7:0]  pin_out;
  logic        probe;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  avalon_gpio_db #(
    .N_IN       (10),
    .N_OUT      (8),
    .DB_CYCLES  (4),
    .SYNC_STAGES(2),
    .INV_MASK   (10'h300)
  ) dut (
    .Clk           (clk),
    .Reset         (Reset),
    .avs_chipselect(avs_chipselect),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pin_in        (pin_in),
    .pin_out       (pin_out)
  );

  always #5 clk = ~clk;

  // Monitor: compares the value produced by this edge.
  always @(posedge clk) begin
    logic  rf;
    logic  pf;
    logic [31:0] act;
    exp_t  e;
    rf = avs_chipselect && avs_read;
    pf = probe;
    if (rf || pf) begin
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got no expectation");
      end else begin
        e = sb.pop_front();
        case (e.src)
          SRC_IRQ:  act = {31'd0, irq};
          SRC_POUT: act = {24'd0, pin_out};
          default:  act = avs_readdata;
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] x,
                          input string nm);
    sb.push_back('{SRC_RD, x, nm});
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = a;
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] x, input string nm);
    sb.push_back('{SRC_RD, x, nm});
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic chk(input int src, input logic [31:0] x, input string nm);
    sb.push_back('{src, x, nm});
    probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    Reset          = 1'b1;
    avs_chipselect = 1'b0;
    avs_address    = 3'd0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = 32'd0;
    pin_in         = 10'h300;
    probe          = 1'b0;
    tick(3);
    Reset = 1'b0;

    // Reset state
    chk(SRC_RDQ, 32'd0, "rst_readdata");
    chk(SRC_IRQ, 32'd0, "rst_irq");
    chk(SRC_POUT, 32'd0, "rst_pin_out");
    bus_read(3'd0, 32'h0, "rst_data_in");
    bus_read(3'd3, 32'h0, "rst_edge_cap");
    bus_read(3'd4, 32'h3FF, "rst_rise_en");
    bus_read(3'd5, 32'h0, "rst_fall_en");
    bus_read(3'd2, 32'h0, "rst_irq_mask");

    // SW[0] rise: stable after edge 6, visible in read at edge 7
    pin_in = 10'h301;
    for (int i = 1; i <= 7; i++)
      bus_read(3'd0, (i == 7) ? 32'h1 : 32'h0, $sformatf("lat_e%0d", i));
    bus_read(3'd3, 32'h1, "lat_cap");
    bus_write(3'd3, 32'h1);
    tick(3);
    pin_in = 10'h300;
    tick(8);
    bus_read(3'd0, 32'h0, "fall_data_in");
    bus_read(3'd3, 32'h0, "fall_no_cap");

    // 3-cycle glitch is rejected
    pin_in = 10'h301;
    tick(3);
    pin_in = 10'h300;
    tick(8);
    bus_read(3'd0, 32'h0, "glitch_data_in");
    bus_read(3'd3, 32'h0, "glitch_cap");

    // IRQ lags capture by one cycle; W1C clears
    bus_write(3'd2, 32'h1);
    pin_in = 10'h301;
    tick(5);
    chk(SRC_IRQ, 32'd0, "irq_e6");
    chk(SRC_IRQ, 32'd1, "irq_e7");
    bus_read(3'd3, 32'h1, "irq_cap");
    bus_write(3'd3, 32'h1);
    chk(SRC_IRQ, 32'd0, "irq_cleared");
    bus_read(3'd3, 32'h0, "w1c_cap");
    pin_in = 10'h300;
    tick(8);

    // KEY[0] press (active low) with fall disabled, then release
    pin_in = 10'h200;
    tick(8);
    bus_read(3'd0, 32'h100, "key_data_in");
    bus_read(3'd3, 32'h100, "key_cap");
    chk(SRC_IRQ, 32'd0, "key_masked_irq");
    bus_write(3'd3, 32'h100);
    bus_read(3'd3, 32'h0, "key_w1c");
    bus_write(3'd5, 32'h100);
    pin_in = 10'h300;
    tick(8);
    bus_read(3'd0, 32'h0, "key_rel_data");
    bus_read(3'd3, 32'h100, "key_rel_cap");
    bus_write(3'd3, 32'h100);

    // Output register, set/clear, width truncation
    bus_write(3'd1, 32'hFFFF_FFF0);
    bus_read(3'd1, 32'hF0, "out_trunc");
    bus_write(3'd6, 32'h03);
    bus_write(3'd7, 32'h10);
    chk(SRC_POUT, 32'hE3, "pin_out_e3");
    bus_read(3'd6, 32'h0, "rd_set_zero");
    bus_read(3'd7, 32'h0, "rd_clr_zero");
    bus_rw(3'd1, 32'h55, 32'hE3, "rw_prewrite");
    bus_read(3'd1, 32'h55, "rw_written");
    // write with chipselect low is ignored
    avs_write     = 1'b1;
    avs_address   = 3'd1;
    avs_writedata = 32'hAA;
    tick(1);
    avs_write = 1'b0;
    bus_read(3'd1, 32'h55, "nocs_ignored");

    // W1C coincident with a new SW[0] rise: set wins
    pin_in = 10'h301;
    tick(5);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, 32'h1, "w1c_vs_set");
    chk(SRC_IRQ, 32'd1, "w1c_vs_set_irq");

    // Reset mid-debounce of SW[1]
    pin_in = 10'h302;
    tick(4);
    Reset  = 1'b1;
    pin_in = 10'h300;
    tick(2);
    Reset = 1'b0;
    tick(8);
    bus_read(3'd0, 32'h0, "mid_rst_data");
    bus_read(3'd3, 32'h0, "mid_rst_cap");
    bus_read(3'd4, 32'h3FF, "mid_rst_rise");
    chk(SRC_IRQ, 32'd0, "mid_rst_irq");
    chk(SRC_POUT, 32'd0, "mid_rst_pout");

    tick(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
